pixie_scan_engine: RTL and testbench

//  Parametrised successor to the fixed-geometry Pixie back end. Generates raster timing, fetches

---
 rtl/pixie_scan_engine.sv | 183 ++++++++++++++++++
 tb/tb_pixie_scan_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_scan_engine.sv
// pixie_scan_engine: raster timing, framebuffer byte fetch and MSB-first pixel serialiser (CPU flags under PIXIE_CPU_FLAGS_EN).
// Outputs lag the h/v counters by one clock; no backpressure - fb_data must be valid the cycle after fb_read_en.
module pixie_scan_engine #(
  parameter int PIXELS_PER_LINE = 112,
  parameter int H_START         = 18,
  parameter int ACTIVE_H        = 64,
  parameter int HSYNC_START     = 2,
  parameter int HSYNC_WIDTH     = 12,
  parameter int LINES_PER_FRAME = 262,
  parameter int V_START         = 64,
  parameter int ACTIVE_V        = 32,
  parameter int LINE_REPEAT     = 1,
  parameter int VSYNC_START     = 0,
  parameter int VSYNC_HEIGHT    = 16,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_on,
  output logic              fb_read_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              video,
  output logic              video_de,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              csync
`ifdef PIXIE_CPU_FLAGS_EN
  ,
  output logic              int_req,
  output logic              efx
`endif
);

  localparam int H_W            = $clog2(PIXELS_PER_LINE);
  localparam int V_W            = $clog2(LINES_PER_FRAME);
  localparam int BYTES_PER_LINE = ACTIVE_H / 8;
  localparam int ACTIVE_LINES   = ACTIVE_V * LINE_REPEAT;
  localparam int R_W            = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

  // True when pos lies in [start, start+width) taken modulo period.
  function automatic logic in_win(input int pos, input int start, input int width, input int period);
    int rel;
    rel = pos - start;
    if (rel < 0) rel = rel + period;
    return rel < width;
  endfunction

  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic              h_wrap, v_wrap;
  int                h_i, v_i;

  logic              disp_en_q, disp_en_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [R_W-1:0]    rep_q, rep_d;

  logic              h_act, v_act, hs_d, vs_d, de_d;
  logic              fetch_hit;
  int                fetch_off;
  logic [ADDR_W-1:0] byte_idx;

  logic              fetch_q;
  logic [7:0]        sh_q;

  logic              video_q, video_de_q, hsync_q, vsync_q;
  logic              hblank_q, vblank_q, csync_q;

  always_comb begin
    h_wrap = (h_q == H_W'(PIXELS_PER_LINE - 1));
    v_wrap = (v_q == V_W'(LINES_PER_FRAME - 1));
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    h_i    = {{(32-H_W){1'b0}}, h_q};
    v_i    = {{(32-V_W){1'b0}}, v_q};
  end

  always_comb begin
    h_act     = in_win(h_i, H_START, ACTIVE_H, PIXELS_PER_LINE);
    v_act     = in_win(v_i, V_START, ACTIVE_LINES, LINES_PER_FRAME);
    hs_d      = in_win(h_i, HSYNC_START, HSYNC_WIDTH, PIXELS_PER_LINE);
    vs_d      = in_win(v_i, VSYNC_START, VSYNC_HEIGHT, LINES_PER_FRAME);
    de_d      = disp_en_q & h_act & v_act;
    // Byte k is requested two columns ahead of its first pixel so the RAM cycle and load fit.
    fetch_off = h_i - (H_START - 2);
    fetch_hit = (fetch_off >= 0) && (fetch_off < ACTIVE_H) && (fetch_off[2:0] == 3'd0);
    byte_idx  = ADDR_W'(fetch_off >>> 3);
  end

  assign fb_read_en = disp_en_q & v_act & fetch_hit;
  assign fb_addr    = fb_read_en ? row_base_q + byte_idx : '0;

  // Row base steps by one framebuffer row every LINE_REPEAT active lines; no divider needed.
  always_comb begin
    row_base_d = row_base_q;
    rep_d      = rep_q;
    disp_en_d  = disp_en_q;
    if (h_wrap) begin
      if (v_d == V_W'(V_START)) begin
        row_base_d = '0;
        rep_d      = '0;
      end else if (v_act) begin
        if (rep_q == R_W'(LINE_REPEAT - 1)) begin
          rep_d      = '0;
          row_base_d = row_base_q + ADDR_W'(BYTES_PER_LINE);
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      if (v_wrap) disp_en_d = disp_on;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      disp_en_q  <= 1'b0;
      row_base_q <= '0;
      rep_q      <= '0;
      fetch_q    <= 1'b0;
      sh_q       <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      disp_en_q  <= disp_en_d;
      row_base_q <= row_base_d;
      rep_q      <= rep_d;
      fetch_q    <= fb_read_en;
      sh_q       <= fetch_q ? fb_data : {sh_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_q    <= 1'b0;
      video_de_q <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      csync_q    <= 1'b1;
    end else begin
      video_q    <= de_d & sh_q[7];
      video_de_q <= de_d;
      hsync_q    <= hs_d;
      vsync_q    <= vs_d;
      hblank_q   <= ~h_act;
      vblank_q   <= ~v_act;
      csync_q    <= ~(hs_d ^ vs_d);
    end
  end

  assign video    = video_q;
  assign video_de = video_de_q;
  assign HSync    = hsync_q;
  assign VSync    = vsync_q;
  assign HBlank   = hblank_q;
  assign VBlank   = vblank_q;
  assign csync    = csync_q;

`ifdef PIXIE_CPU_FLAGS_EN
  logic int_req_q, efx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_req_q <= 1'b0;
      efx_q     <= 1'b0;
    end else begin
      int_req_q <= disp_en_q & in_win(v_i, V_START - 2, 2, LINES_PER_FRAME);
      efx_q     <= disp_en_q & (in_win(v_i, V_START - 4, 4, LINES_PER_FRAME) |
                                in_win(v_i, V_START + ACTIVE_LINES - 4, 4, LINES_PER_FRAME));
    end
  end

  assign int_req = int_req_q;
  assign efx     = efx_q;
`endif

endmodule

// File: tb/tb_pixie_scan_engine.sv
// Bench for pixie_scan_engine: DUT 0 (LINE_REPEAT=1, RAM[a]=a) and DUT 1 (LINE_REPEAT=2, random RAM)
// compared every clock against a frame-arithmetic reference model, plus directed scenario totals.
`timescale 1ns/1ps
module tb_pixie_scan_engine;
  localparam int PPL = 112, HS = 18, AH = 64, HSS = 2, HSW = 12;
  localparam int LPF = 262, VS = 64, AV = 32, VSS = 0, VSH = 16, AW = 10;
  localparam int FRAME = PPL * LPF;
  localparam int LIMIT = 90000;
`ifdef PIXIE_CPU_FLAGS_EN
  localparam int NO = 9;
`else
  localparam int NO = 7;
`endif
  // {video, video_de, HSync, VSync, HBlank, VBlank, csync}
  localparam logic [NO-1:0] RST_OUT = NO'(7'b0000111);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst [2];
  logic            disp [2];
  logic [7:0]      fbd [2];
  logic            rd_en [2];
  logic [AW-1:0]   rd_addr [2];
  logic            vid [2], de [2], hs [2], vs [2], hb [2], vb [2], cs [2];
  logic [NO-1:0]   obs [2];
`ifdef PIXIE_CPU_FLAGS_EN
  logic            ir [2], ef [2];
`endif

  for (genvar d = 0; d < 2; d++) begin : g_obs
`ifdef PIXIE_CPU_FLAGS_EN
    assign obs[d] = {ef[d], ir[d], vid[d], de[d], hs[d], vs[d], hb[d], vb[d], cs[d]};
`else
    assign obs[d] = {vid[d], de[d], hs[d], vs[d], hb[d], vb[d], cs[d]};
`endif
  end

  pixie_scan_engine #(.LINE_REPEAT(1)) u_a (
    .clk(clk), .reset(rst[0]), .disp_on(disp[0]), .fb_read_en(rd_en[0]), .fb_addr(rd_addr[0]),
    .fb_data(fbd[0]), .video(vid[0]), .video_de(de[0]), .HSync(hs[0]), .VSync(vs[0]),
    .HBlank(hb[0]), .VBlank(vb[0]), .csync(cs[0])
`ifdef PIXIE_CPU_FLAGS_EN
    , .int_req(ir[0]), .efx(ef[0])
`endif
  );

  pixie_scan_engine #(.LINE_REPEAT(2)) u_b (
    .clk(clk), .reset(rst[1]), .disp_on(disp[1]), .fb_read_en(rd_en[1]), .fb_addr(rd_addr[1]),
    .fb_data(fbd[1]), .video(vid[1]), .video_de(de[1]), .HSync(hs[1]), .VSync(vs[1]),
    .HBlank(hb[1]), .VBlank(vb[1]), .csync(cs[1])
`ifdef PIXIE_CPU_FLAGS_EN
    , .int_req(ir[1]), .efx(ef[1])
`endif
  );

  logic [7:0]    ram [2][1024];
  int            mh [2], mv [2], mf [2], ph [2], pv [2];
  bit            men [2], pend [2];
  logic [AW-1:0] paddr [2];
  logic [NO-1:0] exp_o [2];

  int n_assert = 0, n_fail = 0, cyc = 0;
  int a_l64 = 0, a_hbl = 0, a_f2_rd = 0, a_f2_de = 0, b_vbl = 0, hs_last = -1, drop = 0;
  int b_cnt [LPF], b_first [LPF];
  int vs_rises [$];
  logic [7:0] byte1 = 8'hxx;
  bit hs_prev = 1'b0, vs_prev = 1'b0;
`ifdef PIXIE_CPU_FLAGS_EN
  int a_ir = 0, a_ef = 0, a_f2_fl = 0;
`endif

  // Expected registered outputs produced from counter position (h, v) of the previous clock.
  function automatic logic [NO-1:0] exp_outs(input int d, input int h, input int v, input bit en);
    int lr, p, row;
    bit hact, vact, dee, hsy, vsy, vbit;
    logic [7:0] byt;
    lr   = d + 1;
    hact = (h >= HS) && (h < HS + AH);
    vact = (v >= VS) && (v < VS + AV * lr);
    dee  = en && hact && vact;
    hsy  = ((h - HSS + PPL) % PPL) < HSW;
    vsy  = ((v - VSS + LPF) % LPF) < VSH;
    vbit = 1'b0;
    if (dee) begin
      p    = h - HS;
      row  = (v - VS) / lr;
      byt  = ram[d][(row * (AH / 8) + p / 8) % 1024];
      vbit = byt[7 - (p % 8)];
    end
    exp_outs = NO'({vbit, dee, hsy, vsy, !hact, !vact, !(hsy ^ vsy)});
`ifdef PIXIE_CPU_FLAGS_EN
    exp_outs[7] = en && (v == VS - 2 || v == VS - 1);
    exp_outs[8] = en && ((v >= VS - 4 && v < VS) || (v >= VS + AV * lr - 4 && v < VS + AV * lr));
`endif
  endfunction

  function automatic void exp_fetch(input int d, input int h, input int v, input bit en,
                                    output bit e, output logic [AW-1:0] a);
    int off;
    off = h - (HS - 2);
    e = en && (v >= VS) && (v < VS + AV * (d + 1)) && (off >= 0) && (off < AH) && (off % 8 == 0);
    a = AW'(((v - VS) / (d + 1)) * (AH / 8) + off / 8);
  endfunction

  task automatic chk_int(input string tag, input int o, input int e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check();
    bit e;
    logic [AW-1:0] ea;
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      assert (obs[d] === exp_o[d]) else begin
        n_fail++;
        $error("FAIL outputs dut%0d cyc=%0d observed=%b expected=%b", d, cyc, obs[d], exp_o[d]);
      end
      e  = 1'b0;
      ea = '0;
      if (!rst[d]) exp_fetch(d, mh[d], mv[d], men[d], e, ea);
      n_assert++;
      assert (rd_en[d] === e) else begin
        n_fail++;
        $error("FAIL fb_read_en dut%0d cyc=%0d observed=%b expected=%b", d, cyc, rd_en[d], e);
      end
      if (e) begin
        n_assert++;
        assert (rd_addr[d] === ea) else begin
          n_fail++;
          $error("FAIL fb_addr dut%0d cyc=%0d observed=%0d expected=%0d", d, cyc, rd_addr[d], ea);
        end
      end
      n_assert++;
      assert (cs[d] === ~(hs[d] ^ vs[d])) else begin
        n_fail++;
        $error("FAIL csync dut%0d cyc=%0d observed=%b expected=%b", d, cyc, cs[d], ~(hs[d] ^ vs[d]));
      end
      // RAM answers only in the cycle after the strobe; garbage otherwise.
      fbd[d]   = pend[d] ? ram[d][paddr[d]] : 8'($urandom);
      pend[d]  = rd_en[d];
      paddr[d] = rd_addr[d];
    end
    if (mf[0] == 1 && mv[0] == VS && rd_en[0]) a_l64++;
    if (mf[0] == 0 && pv[0] == 100 && !hb[0]) a_hbl++;
    if (mf[0] == 2 && rd_en[0]) a_f2_rd++;
    if (mf[0] == 2 && de[0]) a_f2_de++;
    if (mf[0] == 1 && pv[0] == VS && ph[0] >= HS + 8 && ph[0] < HS + 16) byte1[7 - (ph[0] - HS - 8)] = vid[0];
    if (hs[0] && !hs_prev) begin
      if (hs_last >= 0) chk_int("hsync_period", cyc - hs_last, PPL);
      hs_last = cyc;
    end
    if (vs[0] && !vs_prev) vs_rises.push_back(cyc);
    hs_prev = hs[0];
    vs_prev = vs[0];
    if (mf[1] == 1 && rd_en[1]) begin
      if (b_cnt[mv[1]] == 0) b_first[mv[1]] = int'(rd_addr[1]);
      b_cnt[mv[1]]++;
    end
    if (mf[1] == 1 && !vb[1]) b_vbl++;
`ifdef PIXIE_CPU_FLAGS_EN
    if (mf[0] == 1 && ir[0]) a_ir++;
    if (mf[0] == 1 && ef[0]) a_ef++;
    if (mf[0] == 2 && (ir[0] || ef[0])) a_f2_fl++;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      ph[d] = mh[d];
      pv[d] = mv[d];
      if (rst[d]) begin
        exp_o[d] = RST_OUT;
        mh[d] = 0; mv[d] = 0; mf[d] = 0; men[d] = 1'b0;
      end else begin
        exp_o[d] = exp_outs(d, mh[d], mv[d], men[d]);
        if (mh[d] == PPL - 1) begin
          mh[d] = 0;
          if (mv[d] == LPF - 1) begin
            mv[d] = 0;
            mf[d]++;
            men[d] = disp[d];
          end else begin
            mv[d]++;
          end
        end else begin
          mh[d]++;
        end
      end
    end
    #1;
    check();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      ram[0][a] = 8'(a);
      ram[1][a] = 8'($urandom);
    end
    for (int l = 0; l < LPF; l++) begin
      b_cnt[l]   = 0;
      b_first[l] = -1;
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; disp[d] = 1'b1; fbd[d] = 8'h00;
      mh[d] = 0; mv[d] = 0; mf[d] = 0; ph[d] = 0; pv[d] = 0;
      men[d] = 1'b0; pend[d] = 1'b0; paddr[d] = '0; exp_o[d] = RST_OUT;
    end
    drop = $urandom_range(200, 100);

    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      assert (obs[d] === RST_OUT && rd_en[d] === 1'b0 && rd_addr[d] === AW'(0)) else begin
        n_fail++;
        $error("FAIL reset_state dut%0d observed=%b/%b/%0d expected=%b/0/0", d, obs[d], rd_en[d], rd_addr[d], RST_OUT);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Mid-frame asynchronous reset of DUT 1 at v=70, h=40.
    while (!(mv[1] == 70 && mh[1] == 40) && cyc < LIMIT) step();
    rst[1] = 1'b1;
    mh[1] = 0; mv[1] = 0; mf[1] = 0; men[1] = 1'b0; pend[1] = 1'b0;
    exp_o[1] = RST_OUT;
    #1;
    n_assert++;
    assert (obs[1] === RST_OUT && rd_en[1] === 1'b0 && rd_addr[1] === AW'(0)) else begin
      n_fail++;
      $error("FAIL async_reset observed=%b/%b/%0d expected=%b/0/0", obs[1], rd_en[1], rd_addr[1], RST_OUT);
    end
    step();
    step();
    rst[1] = 1'b0;
    #1;
    chk_int("vsync_before_first_edge", int'(vs[1]), 0);
    step();
    chk_int("vsync_first_edge", int'(vs[1]), 1);

    // Frame 1 of DUT 0 fetches; disp_on drops part way so frame 2 is dark.
    while (mf[0] < 1 && cyc < LIMIT) step();
    while (mv[0] < drop && cyc < LIMIT) step();
    disp[0] = 1'b0;
    while ((mf[0] < 2 || mv[0] < 130) && cyc < LIMIT) step();

    chk_int("cycle_budget", int'(cyc < LIMIT), 1);
    chk_int("a_line64_reads", a_l64, 8);
    chk_int("a_byte1_video", int'(byte1), 8'h01);
    chk_int("a_hblank_low", a_hbl, 64);
    chk_int("a_dark_frame_reads", a_f2_rd, 0);
    chk_int("a_dark_frame_de", a_f2_de, 0);
    chk_int("a_vsync_rises", int'(vs_rises.size() >= 3), 1);
    for (int i = 1; i < vs_rises.size(); i++) chk_int("vsync_period", vs_rises[i] - vs_rises[i-1], FRAME);
    chk_int("b_line64_reads", b_cnt[64], 8);
    chk_int("b_line64_first", b_first[64], 0);
    chk_int("b_line65_reads", b_cnt[65], 8);
    chk_int("b_line65_first", b_first[65], 0);
    chk_int("b_line66_reads", b_cnt[66], 8);
    chk_int("b_line66_first", b_first[66], 8);
    chk_int("b_line127_reads", b_cnt[127], 8);
    chk_int("b_line127_first", b_first[127], 248);
    chk_int("b_line128_reads", b_cnt[128], 0);
    chk_int("b_vblank_low", b_vbl, 64 * PPL);
`ifdef PIXIE_CPU_FLAGS_EN
    chk_int("a_int_req_cycles", a_ir, 2 * PPL);
    chk_int("a_efx_cycles", a_ef, 8 * PPL);
    chk_int("a_dark_frame_flags", a_f2_fl, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
